// File: rtl/pagerank_pkg.sv
// Shared definitions for the PageRank scatter/reduce datapath: lane count,
// lane-mask type and the default data/counter widths.
package pagerank_pkg;

  localparam int NLANES = 4;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef logic [NLANES-1:0] lane_mask_t;

endpackage

// File: rtl/pagerank_scatter_lane.sv
// Single-entry val/rdy output buffer for one scatter lane. The parent only
// raises load when free is high, so a load never overwrites an undelivered word.
module pagerank_scatter_lane
  import pagerank_pkg::*;
#(
  parameter int nbits = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [nbits-1:0] data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [nbits-1:0] out_msg,
  output logic             free
);

  logic             val_reg;
  logic [nbits-1:0] msg_reg;

  // Free when empty or when the held word is leaving this cycle.
  assign free    = ~val_reg | out_rdy;
  assign out_val = val_reg;
  assign out_msg = msg_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      val_reg <= 1'b0;
      msg_reg <= '0;
    end else if (load) begin
      val_reg <= 1'b1;
      msg_reg <= data;
    end else if (out_rdy) begin
      // Drained without reload: word stays in msg_reg but is no longer valid.
      val_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/pagerank_scatter_unit.sv
// Fans one rank word out to any subset of the PE input lanes. A message is
// accepted only when every targeted lane can take it, so broadcasts are atomic.
module pagerank_scatter_unit
  import pagerank_pkg::*;
#(
  parameter int nbits = DATA_W,
  parameter int cbits = CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_val,
  output logic                    in_rdy,
  input  logic [nbits-1:0]        in_msg,
  input  lane_mask_t              in_mask,
  output lane_mask_t              out_val,
  input  lane_mask_t              out_rdy,
  output logic [NLANES*nbits-1:0] out_msg,
  output logic [cbits-1:0]        count
);

  lane_mask_t       free;
  lane_mask_t       load;
  logic             accept;
  logic [cbits-1:0] count_reg;

  // Untargeted lanes never block; in_val deliberately does not feed in_rdy.
  assign in_rdy = &(~in_mask | free);
  assign accept = in_val & in_rdy;
  assign count  = count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NLANES; gi++) begin : g_lane
      assign load[gi] = accept & in_mask[gi];

      pagerank_scatter_lane #(.nbits(nbits)) u_lane (
        .clk     (clk),
        .reset   (reset),
        .load    (load[gi]),
        .data    (in_msg),
        .out_val (out_val[gi]),
        .out_rdy (out_rdy[gi]),
        .out_msg (out_msg[gi*nbits +: nbits]),
        .free    (free[gi])
      );
    end
  endgenerate

  // Zero-mask messages are consumed but not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (accept && (in_mask != '0)) begin
      count_reg <= count_reg + cbits'(1);
    end
  end

endmodule
